fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default FETCH_RESET_PC (32'h0000_3000), word-aligned PC loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: imem_req  output  1  fetch request valid.
REQ-005 Port: imem_addr  output  32  byte address of fetch; bits [1:0] always 0.
REQ-006 Port: imem_ack  input  1  imem_rdata valid for the address presented this cycle.
REQ-007 Port: imem_rdata  input  32  instruction word.
REQ-008 Port: stall  input  1  downstream decoder/execute cannot consume the held instruction.
REQ-009 Port: redirect_valid  input  1  one-cycle pulse: taken branch, j, jal or jr resolved.
REQ-010 Port: redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-011 Port: sys_halt  input  1  one-cycle pulse from syscall decode; stop fetching.
REQ-012 Port: instr_valid  output  1  instr/op/funct/pc_out hold a live instruction.
REQ-013 Port: instr  output  32  held instruction word.
REQ-014 Port: op  output  6  instr[31:26], feeds controller op.
REQ-015 Port: funct  output  6  instr[5:0], feeds controller funct.
REQ-016 Port: pc_out  output  32  address of held instruction.
REQ-017 Port: pc_plus4  output  32  pc_out + 4, used for jal link and branch base.
REQ-018 Port: halted  output  1  unit in HALT state.
REQ-019 Port: fetch_count  output  32  consumed-instruction counter (present only with FETCH_COUNT_EN).

Function
REQ-020 FSM states SHALL be REQ, HOLD and HALT.
REQ-021 REQ: imem_req=1, imem_addr=pc; on imem_ack, latch imem_rdata into instr and pc into pc_out; go to HOLD next cycle.
REQ-022 HOLD: instr_valid=1, imem_req=0; if stall=0 the instruction is consumed, pc<=pc+4, go to REQ; if stall=1, hold all outputs unchanged.
REQ-023 Minimum throughput SHALL be one instruction per 2 cycles (ack in first REQ cycle, no stall).
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 redirect_valid in REQ or HOLD SHALL set pc<={redirect_pc[31:2],2'b00}, drop instr_valid, and enter REQ next cycle, regardless of stall.
REQ-026 imem_ack in the same cycle as redirect_valid SHALL be discarded (instr and pc_out not updated).
REQ-027 sys_halt SHALL enter HALT next cycle from any state; HALT drives imem_req=0, instr_valid=0, halted=1 until rst.
REQ-028 sys_halt and redirect_valid together: halt wins, pc not updated.
REQ-029 op, funct and pc_plus4 SHALL be combinational functions of instr and pc_out.

Reset
REQ-030 rst SHALL set pc=RESET_PC, state=REQ, instr=0, pc_out=RESET_PC, instr_valid=0, halted=0, fetch_count=0; imem_req=1 on the first cycle after rst deasserts.
REQ-031 rst SHALL override all other inputs, including mid-request and HALT.

Configuration
REQ-032 With FETCH_COUNT_EN defined: fetch_count increments (mod 2^32) on each HOLD cycle with stall=0 and no redirect/halt; without it: port and counter absent.

Structure
REQ-033 Shared package SHALL hold FETCH_RESET_PC, FSM state encoding, and the op/funct field bit positions used by the controller.
REQ-034 No sub-module; single flat module.

Verification
REQ-035 Reset, ack every cycle, no stall -> imem_addr 0x3000, 0x3004, 0x3008 on cycles 1, 3, 5; instr_valid on cycles 2, 4, 6.
REQ-036 Hold instr 0x012A4020 with stall=1 for 3 cycles -> op=0, funct=0x20, pc_out constant, no new imem_req.
REQ-037 redirect_pc=0x3043 during REQ with imem_ack=1 -> data discarded, next imem_addr=0x3040.
REQ-038 pc=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.
REQ-039 sys_halt with redirect_valid the same cycle -> halted=1, imem_req=0 thereafter, pc unchanged; rst -> imem_addr 0x3000.
REQ-040 FETCH_COUNT_EN: 5 instructions consumed, one redirect squash -> fetch_count=5.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared definitions for the instruction fetch unit and the
//            controller that consumes its op/funct fields:
//              - FETCH_RESET_PC : default word-aligned reset PC
//              - fetch_state_e  : fetch FSM state encoding
//              - OP_* / FUNCT_* : instruction field bit positions
//              - word_align()   : clears the byte-offset bits of an address
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch unit. Requests one word
//            from instruction memory, holds it for the decoder until it is
//            consumed, then advances the PC. Supports branch/jump redirect
//            and a sticky halt raised by syscall decode.
// Ports    : clk, rst (sync, active-high)
//            imem_req/imem_addr -> memory, imem_ack/imem_rdata <- memory
//            stall, redirect_valid/redirect_pc, sys_halt <- pipeline
//            instr_valid, instr, op, funct, pc_out, pc_plus4, halted -> pipeline
//            fetch_count -> consumed-instruction counter (FETCH_COUNT_EN only)
// Config   : define FETCH_COUNT_EN to add the fetch_count port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        sys_halt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_out_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic         halted_q;

  logic [31:0]  redirect_pc_d;
  logic [31:0]  pc_seq_d;

  assign redirect_pc_d = word_align(redirect_pc);
  assign pc_seq_d      = pc_q + 32'd4;  // wraps modulo 2^32

  // FSM with outputs registered alongside the state. Priority within a
  // state: halt, then redirect, then the normal handshake. A redirect in
  // REQ discards any ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      pc_out_q      <= RESET_PC;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (sys_halt) begin
            state_q       <= ST_HALT;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc_d;
          end else if (imem_ack) begin
            instr_q       <= imem_rdata;
            pc_out_q      <= pc_q;
            state_q       <= ST_HOLD;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (sys_halt) begin
            state_q       <= ST_HALT;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (redirect_valid) begin
            pc_q          <= redirect_pc_d;
            state_q       <= ST_REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end else if (!stall) begin
            pc_q          <= pc_seq_d;
            state_q       <= ST_REQ;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        ST_HALT: begin
          // Sticky until reset.
        end
        default: begin
          state_q       <= ST_HALT;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (state_q == ST_HOLD && !stall && !redirect_valid && !sys_halt) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;
  assign op          = instr_q[OP_MSB:OP_LSB];
  assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pc_plus4    = pc_out_q + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: a table of directed
//            vectors, hand-written corner sequences (PC wrap, counter) and
//            a randomized phase checked against a transaction-level model.
// Config   : FETCH_COUNT_EN enables the fetch_count checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        sys_halt = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halted;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .sys_halt       (sys_halt),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .op             (op),
    .funct          (funct),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .halted         (halted)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Transaction-level model: where the next fetch goes, whether a word is
  // being held for the decoder, and whether fetching has stopped for good.
  logic [31:0] m_pc;
  logic        m_have;
  logic        m_stop;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic [31:0] m_cnt;

  task automatic model_update(input logic r, a, input logic [31:0] d,
                              input logic s, rv, input logic [31:0] rp,
                              input logic h);
    if (r) begin
      m_pc = RST_PC; m_have = 0; m_stop = 0;
      m_instr = 0; m_pcout = RST_PC; m_cnt = 0;
    end else if (m_stop) begin
      // nothing changes once stopped
    end else if (h) begin
      m_stop = 1;
    end else if (rv) begin
      m_pc   = rp - (rp % 4);
      m_have = 0;
    end else if (!m_have) begin
      if (a) begin
        m_have  = 1;
        m_instr = d;
        m_pcout = m_pc;
      end
    end else if (!s) begin
      m_have = 0;
      m_pc   = m_pc + 4;
      m_cnt  = m_cnt + 1;
    end
  endtask

  task automatic step(input logic r, a, input logic [31:0] d,
                      input logic s, rv, input logic [31:0] rp,
                      input logic h);
    @(negedge clk);
    rst = r; imem_ack = a; imem_rdata = d; stall = s;
    redirect_valid = rv; redirect_pc = rp; sys_halt = h;
    @(posedge clk);
    model_update(r, a, d, s, rv, rp, h);
    #1;
  endtask

  task automatic check(input string tag, input logic e_req,
                       input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pcout,
                       input logic e_halted);
    logic bad;
    logic [5:0]  e_op;
    logic [5:0]  e_fn;
    logic [31:0] e_p4;
    bad  = 1'b0;
    e_op = 6'(e_instr / 32'h0400_0000);
    e_fn = 6'(e_instr % 64);
    e_p4 = e_pcout + 4;
    n_vec++;
    if (imem_req !== e_req) begin
      $display("FAIL %s imem_req got %0b want %0b", tag, imem_req, e_req); bad = 1;
    end
    if (imem_addr !== e_addr) begin
      $display("FAIL %s imem_addr got %h want %h", tag, imem_addr, e_addr); bad = 1;
    end
    if (instr_valid !== e_valid) begin
      $display("FAIL %s instr_valid got %0b want %0b", tag, instr_valid, e_valid); bad = 1;
    end
    if (instr !== e_instr) begin
      $display("FAIL %s instr got %h want %h", tag, instr, e_instr); bad = 1;
    end
    if (pc_out !== e_pcout) begin
      $display("FAIL %s pc_out got %h want %h", tag, pc_out, e_pcout); bad = 1;
    end
    if (op !== e_op || funct !== e_fn || pc_plus4 !== e_p4) begin
      $display("FAIL %s op/funct/pc_plus4 got %h/%h/%h want %h/%h/%h",
               tag, op, funct, pc_plus4, e_op, e_fn, e_p4); bad = 1;
    end
    if (halted !== e_halted) begin
      $display("FAIL %s halted got %0b want %0b", tag, halted, e_halted); bad = 1;
    end
    if (bad) n_miss++;
  endtask

  task automatic check_model(input string tag);
    check(tag, !m_stop && !m_have, m_pc, m_have && !m_stop,
          m_instr, m_pcout, m_stop);
`ifdef FETCH_COUNT_EN
    n_vec++;
    if (fetch_count !== m_cnt) begin
      $display("FAIL %s fetch_count got %0d want %0d", tag, fetch_count, m_cnt);
      n_miss++;
    end
`endif
  endtask

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        stall, rv;
    logic [31:0] rpc;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcout;
    logic        e_halted;
  } vec_t;

  vec_t vt[14];

  initial begin
    //          rst ack rdata          stl rv  rpc            hlt  req addr           vld instr          pc_out         hlt
    vt[0]  = '{1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_3000, 0, 32'h0,          32'h0000_3000, 0};
    vt[1]  = '{0, 1, 32'h1111_1111,  0, 0, 32'h0,          0,   0, 32'h0000_3000, 1, 32'h1111_1111,  32'h0000_3000, 0};
    vt[2]  = '{0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_3004, 0, 32'h1111_1111,  32'h0000_3000, 0};
    vt[3]  = '{0, 1, 32'h012A_4020,  0, 0, 32'h0,          0,   0, 32'h0000_3004, 1, 32'h012A_4020,  32'h0000_3004, 0};
    vt[4]  = '{0, 1, 32'hAAAA_AAAA,  1, 0, 32'h0,          0,   0, 32'h0000_3004, 1, 32'h012A_4020,  32'h0000_3004, 0};
    vt[5]  = '{0, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h0000_3004, 1, 32'h012A_4020,  32'h0000_3004, 0};
    vt[6]  = '{0, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h0000_3004, 1, 32'h012A_4020,  32'h0000_3004, 0};
    vt[7]  = '{0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0000_3008, 0, 32'h012A_4020,  32'h0000_3004, 0};
    vt[8]  = '{0, 1, 32'hDEAD_BEEF,  0, 1, 32'h0000_3043,  0,   1, 32'h0000_3040, 0, 32'h012A_4020,  32'h0000_3004, 0};
    vt[9]  = '{0, 1, 32'h2222_2222,  0, 0, 32'h0,          0,   0, 32'h0000_3040, 1, 32'h2222_2222,  32'h0000_3040, 0};
    vt[10] = '{0, 0, 32'h0,          1, 1, 32'h0000_5000,  0,   1, 32'h0000_5000, 0, 32'h2222_2222,  32'h0000_3040, 0};
    vt[11] = '{0, 1, 32'h3333_3333,  0, 1, 32'h0000_7000,  1,   0, 32'h0000_5000, 0, 32'h2222_2222,  32'h0000_3040, 1};
    vt[12] = '{0, 1, 32'h4444_4444,  0, 0, 32'h0,          0,   0, 32'h0000_5000, 0, 32'h2222_2222,  32'h0000_3040, 1};
    vt[13] = '{1, 1, 32'h5555_5555,  0, 1, 32'h0000_9000,  1,   1, 32'h0000_3000, 0, 32'h0,          32'h0000_3000, 0};

    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst, vt[i].ack, vt[i].rdata, vt[i].stall, vt[i].rv, vt[i].rpc, vt[i].halt);
      check($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
            vt[i].e_instr, vt[i].e_pcout, vt[i].e_halted);
    end

    // PC wrap: fetch from the top word, consume it, next fetch is address 0.
    step(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFE, 0);
    check("wrap_redir", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0000_3000, 0);
    step(0, 1, 32'h0800_0001, 0, 0, 32'h0, 0);
    check("wrap_hold", 0, 32'hFFFF_FFFC, 1, 32'h0800_0001, 32'hFFFF_FFFC, 0);
    step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    check("wrap_next", 1, 32'h0000_0000, 0, 32'h0800_0001, 32'hFFFF_FFFC, 0);

    // Five consumed instructions with one squashed by a redirect in HOLD.
    step(1, 0, 32'h0, 0, 0, 32'h0, 0);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 32'h1000 + k, 0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    end
    step(0, 1, 32'hBAD0_0000, 0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 1, 32'h0000_3100, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 32'h2000 + k, 0, 0, 32'h0, 0);
      step(0, 0, 32'h0, 0, 0, 32'h0, 0);
    end
    check("cnt_seq", 1, 32'h0000_310C, 0, 32'h0000_2002, 32'h0000_3108, 0);
`ifdef FETCH_COUNT_EN
    n_vec++;
    if (fetch_count !== 32'd5) begin
      $display("FAIL fetch_count5 got %0d want 5", fetch_count);
      n_miss++;
    end
`endif

    // Randomized phase against the model.
    for (int c = 0; c < 600; c++) begin
      logic        r_rst, r_ack, r_stl, r_rv, r_h;
      logic [31:0] r_d, r_rp;
      r_rst = ($urandom_range(0, 79) == 0);
      r_h   = ($urandom_range(0, 49) == 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_ack = ($urandom_range(0, 1) == 0);
      r_stl = ($urandom_range(0, 2) == 0);
      r_d   = $urandom;
      r_rp  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : $urandom;
      step(r_rst, r_ack, r_d, r_stl, r_rv, r_rp, r_h);
      check_model($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
